// File: rtl/pdp8_pkg.sv
// pdp8_pkg: constants and types shared by the PDP-8 memory subsystem.
//   - PDP8_AW / PDP8_DW : core memory address / data widths (4K x 12)
//   - GNT_*             : GRANT encoding (owner of the current memory cycle)
//   - arb_state_e       : memory cycle FSM states
package pdp8_pkg;

    localparam int PDP8_AW = 12;
    localparam int PDP8_DW = 12;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_CPU  = 2'd1;
    localparam logic [1:0] GNT_DMA  = 2'd2;
    localparam logic [1:0] GNT_PNL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_cycle_timer.sv
// mem_cycle_timer: loadable down-counter that times the WAIT phase.
//   CLK, RESET : clock, synchronous active-high reset
//   load       : preload the counter (asserted during ISSUE)
//   run        : counting enable (asserted during WAIT)
//   done       : high in the last WAIT cycle, i.e. after LAT cycles of run
module mem_cycle_timer #(
    parameter int LAT = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic load,
    input  logic run,
    output logic done
);

    logic [2:0] cnt;

    // Loaded with LAT-1 so that the count hits zero in the LAT-th WAIT cycle.
    always_ff @(posedge CLK) begin
        if (RESET)
            cnt <= 3'd0;
        else if (load)
            cnt <= 3'(LAT - 1);
        else if (run && cnt != 3'd0)
            cnt <= cnt - 3'd1;
    end

    assign done = run && (cnt == 3'd0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port core memory arbiter / cycle controller.
// Requesters: CPU, data-break (DMA) and, with PANEL_PORT_EN defined, the
// front panel (PNL_* ports). Priority DMA > PNL > CPU, except that the CPU
// wins once CPU_MAX_SKIP non-CPU grants were made while it was waiting.
// Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK.
//   CLK, RESET               : clock, synchronous active-high reset
//   <R>_REQ/_WE/_ADDR/_WDATA : requester inputs, held stable until <R>_ACK
//   <R>_ACK                  : one-cycle completion pulse
//   RDATA                    : read data, valid in the ACK cycle
//   MEM_EN/_WE/_ADDR/_WDATA  : memory strobe and latched request
//   MEM_RDATA                : memory read data, valid MEM_LAT cycles after MEM_EN
//   GRANT                    : current owner (GNT_* encoding), BUSY : not IDLE
// Build option: PANEL_PORT_EN adds the front-panel requester.
module mem_arbiter
    import pdp8_pkg::*;
#(
    parameter int AW           = PDP8_AW,
    parameter int DW           = PDP8_DW,
    parameter int MEM_LAT      = 2,
    parameter int CPU_MAX_SKIP = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_WDATA,
    output logic          CPU_ACK,
    input  logic          DMA_REQ,
    input  logic          DMA_WE,
    input  logic [AW-1:0] DMA_ADDR,
    input  logic [DW-1:0] DMA_WDATA,
    output logic          DMA_ACK,
`ifdef PANEL_PORT_EN
    input  logic          PNL_REQ,
    input  logic          PNL_WE,
    input  logic [AW-1:0] PNL_ADDR,
    input  logic [DW-1:0] PNL_WDATA,
    output logic          PNL_ACK,
`endif
    output logic [DW-1:0] RDATA,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic [1:0]    GRANT,
    output logic          BUSY
);

    localparam int SKW = $clog2(CPU_MAX_SKIP + 2);
    localparam logic [SKW-1:0] SKIP_MAX = SKW'(CPU_MAX_SKIP);

    // Without the panel the PNL requester is tied off, so one arbitration
    // path serves both builds and GNT_PNL can never be selected.
    logic          pnl_req, pnl_we;
    logic [AW-1:0] pnl_addr;
    logic [DW-1:0] pnl_wdata;
`ifdef PANEL_PORT_EN
    assign pnl_req   = PNL_REQ;
    assign pnl_we    = PNL_WE;
    assign pnl_addr  = PNL_ADDR;
    assign pnl_wdata = PNL_WDATA;
`else
    assign pnl_req   = 1'b0;
    assign pnl_we    = 1'b0;
    assign pnl_addr  = '0;
    assign pnl_wdata = '0;
`endif

    arb_state_e     state, state_nxt;
    logic [SKW-1:0] skip;
    logic           we_q;
    logic           tmr_done;
    logic [1:0]     gnt_nxt;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic           cpu_force;
    logic           grant_now;
    logic           ack_now;

    // Anti-starvation: a waiting CPU overrides priority once skip saturates.
    assign cpu_force = CPU_REQ && (skip == SKIP_MAX);

    always_comb begin
        gnt_nxt = GNT_NONE;
        if (cpu_force)    gnt_nxt = GNT_CPU;
        else if (DMA_REQ) gnt_nxt = GNT_DMA;
        else if (pnl_req) gnt_nxt = GNT_PNL;
        else if (CPU_REQ) gnt_nxt = GNT_CPU;
    end

    always_comb begin
        sel_we    = CPU_WE;
        sel_addr  = CPU_ADDR;
        sel_wdata = CPU_WDATA;
        case (gnt_nxt)
            GNT_DMA: begin
                sel_we    = DMA_WE;
                sel_addr  = DMA_ADDR;
                sel_wdata = DMA_WDATA;
            end
            GNT_PNL: begin
                sel_we    = pnl_we;
                sel_addr  = pnl_addr;
                sel_wdata = pnl_wdata;
            end
            default: ;
        endcase
    end

    assign grant_now = (state == ST_IDLE) && (gnt_nxt != GNT_NONE);
    assign ack_now   = (state == ST_WAIT) && tmr_done;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_now) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (tmr_done) state_nxt = ST_ACK;
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    mem_cycle_timer #(.LAT(MEM_LAT)) u_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .load  (state == ST_ISSUE),
        .run   (state == ST_WAIT),
        .done  (tmr_done)
    );

    // Every output is a register loaded from next-state decisions, so no
    // requester input reaches an output within the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            skip      <= '0;
            we_q      <= 1'b0;
            GRANT     <= GNT_NONE;
            BUSY      <= 1'b0;
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            RDATA     <= '0;
            CPU_ACK   <= 1'b0;
            DMA_ACK   <= 1'b0;
`ifdef PANEL_PORT_EN
            PNL_ACK   <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            BUSY   <= (state_nxt != ST_IDLE);
            MEM_EN <= grant_now;
            MEM_WE <= grant_now && sel_we;

            if (grant_now) begin
                GRANT     <= gnt_nxt;
                we_q      <= sel_we;
                MEM_ADDR  <= sel_addr;
                MEM_WDATA <= sel_wdata;
                if (gnt_nxt == GNT_CPU || !CPU_REQ)
                    skip <= '0;
                else if (skip != SKIP_MAX)
                    skip <= skip + 1'b1;
            end else if (state == ST_ACK) begin
                GRANT <= GNT_NONE;
            end

            CPU_ACK <= ack_now && (GRANT == GNT_CPU);
            DMA_ACK <= ack_now && (GRANT == GNT_DMA);
`ifdef PANEL_PORT_EN
            PNL_ACK <= ack_now && (GRANT == GNT_PNL);
`endif

            // Only reads update RDATA; a write leaves the last read visible.
            if (ack_now && !we_q)
                RDATA <= MEM_RDATA;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (MEM_LAT=2,
// CPU_MAX_SKIP=2). Includes a core memory model whose read data is valid
// only in the MEM_LAT-th cycle after MEM_EN.
module tb_mem_arbiter;
    import pdp8_pkg::*;

    localparam int AW = 12;
    localparam int DW = 12;
    localparam int MEM_LAT = 2;
    localparam int CPU_MAX_SKIP = 2;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          CPU_REQ, CPU_WE, CPU_ACK;
    logic [AW-1:0] CPU_ADDR;
    logic [DW-1:0] CPU_WDATA;
    logic          DMA_REQ, DMA_WE, DMA_ACK;
    logic [AW-1:0] DMA_ADDR;
    logic [DW-1:0] DMA_WDATA;
`ifdef PANEL_PORT_EN
    logic          PNL_REQ, PNL_WE, PNL_ACK;
    logic [AW-1:0] PNL_ADDR;
    logic [DW-1:0] PNL_WDATA;
`endif
    logic [DW-1:0] RDATA;
    logic          MEM_EN, MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic [1:0]    GRANT;
    logic          BUSY;

    int n_run  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .CPU_MAX_SKIP(CPU_MAX_SKIP)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CPU_REQ   (CPU_REQ),
        .CPU_WE    (CPU_WE),
        .CPU_ADDR  (CPU_ADDR),
        .CPU_WDATA (CPU_WDATA),
        .CPU_ACK   (CPU_ACK),
        .DMA_REQ   (DMA_REQ),
        .DMA_WE    (DMA_WE),
        .DMA_ADDR  (DMA_ADDR),
        .DMA_WDATA (DMA_WDATA),
        .DMA_ACK   (DMA_ACK),
`ifdef PANEL_PORT_EN
        .PNL_REQ   (PNL_REQ),
        .PNL_WE    (PNL_WE),
        .PNL_ADDR  (PNL_ADDR),
        .PNL_WDATA (PNL_WDATA),
        .PNL_ACK   (PNL_ACK),
`endif
        .RDATA     (RDATA),
        .MEM_EN    (MEM_EN),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .GRANT     (GRANT),
        .BUSY      (BUSY)
    );

    // Core memory model: presets 0o200 during reset, garbage outside the
    // single cycle in which read data is valid.
    logic [DW-1:0] mem [0:4095];
    int            rd_cnt = 0;
    logic [AW-1:0] rd_addr = '0;

    always @(posedge CLK) begin
        if (RESET)
            mem[12'o200] <= 12'o7402;
        if (MEM_EN && MEM_WE)
            mem[MEM_ADDR] <= MEM_WDATA;
        if (MEM_EN && !MEM_WE) begin
            rd_cnt  <= MEM_LAT;
            rd_addr <= MEM_ADDR;
        end else if (rd_cnt > 0) begin
            rd_cnt <= rd_cnt - 1;
        end
    end
    assign MEM_RDATA = (rd_cnt == 1) ? mem[rd_addr] : 12'o5555;

    // Cycle counter and MEM_EN log (owner and cycle of each strobe).
    int         cyc = 0;
    int         en_n = 0;
    int         g3_cnt = 0;
    logic [1:0] en_gnt [0:255];
    int         en_cyc [0:255];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (GRANT == GNT_PNL)
            g3_cnt <= g3_cnt + 1;
        if (MEM_EN && en_n < 256) begin
            en_gnt[en_n] <= GRANT;
            en_cyc[en_n] <= cyc;
            en_n         <= en_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    // Step to just after the next falling edge (inputs change, outputs sampled).
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && BUSY; i++) step();
        check(tag, BUSY, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acks;
        logic [1:0] exp_gnt [0:5];
        exp_gnt[0] = GNT_DMA; exp_gnt[1] = GNT_DMA; exp_gnt[2] = GNT_CPU;
        exp_gnt[3] = GNT_DMA; exp_gnt[4] = GNT_DMA; exp_gnt[5] = GNT_CPU;

        RESET = 1'b1;
        CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
        DMA_REQ = 1'b0; DMA_WE = 1'b0; DMA_ADDR = '0; DMA_WDATA = '0;
`ifdef PANEL_PORT_EN
        PNL_REQ = 1'b0; PNL_WE = 1'b0; PNL_ADDR = '0; PNL_WDATA = '0;
`endif
        repeat (3) step();

        // Reset values
        check("rst_mem_en", MEM_EN, 1'b0);
        check("rst_mem_we", MEM_WE, 1'b0);
        check("rst_cpu_ack", CPU_ACK, 1'b0);
        check("rst_dma_ack", DMA_ACK, 1'b0);
        check("rst_grant", GRANT, GNT_NONE);
        check("rst_busy", BUSY, 1'b0);
        check("rst_addr", MEM_ADDR, 12'o0);
        check("rst_wdata", MEM_WDATA, 12'o0);
        check("rst_rdata", RDATA, 12'o0);
        RESET = 1'b0;
        step();

        // Single CPU read of 0o200
        CPU_ADDR = 12'o200; CPU_WE = 1'b0; CPU_REQ = 1'b1;
        step();
        check("rd_mem_en", MEM_EN, 1'b1);
        check("rd_mem_we", MEM_WE, 1'b0);
        check("rd_grant", GRANT, GNT_CPU);
        check("rd_addr", MEM_ADDR, 12'o200);
        check("rd_busy", BUSY, 1'b1);
        step();
        check("rd_en_one_cycle", MEM_EN, 1'b0);
        repeat (MEM_LAT) step();
        check("rd_ack", CPU_ACK, 1'b1);
        check("rd_data", RDATA, 12'o7402);
        CPU_REQ = 1'b0;
        step();
        check("rd_ack_one_cycle", CPU_ACK, 1'b0);
        check("rd_idle_busy", BUSY, 1'b0);
        check("rd_idle_grant", GRANT, GNT_NONE);

        // CPU write of 0o1234 to 0o0017
        CPU_ADDR = 12'o0017; CPU_WDATA = 12'o1234; CPU_WE = 1'b1; CPU_REQ = 1'b1;
        step();
        check("wr_mem_en", MEM_EN, 1'b1);
        check("wr_mem_we", MEM_WE, 1'b1);
        check("wr_addr", MEM_ADDR, 12'o0017);
        check("wr_wdata", MEM_WDATA, 12'o1234);
        repeat (MEM_LAT + 1) step();
        check("wr_ack", CPU_ACK, 1'b1);
        check("wr_rdata_kept", RDATA, 12'o7402);
        CPU_REQ = 1'b0; CPU_WE = 1'b0;
        step();
        check("wr_mem_content", mem[12'o0017], 12'o1234);
        check("wr_idle", BUSY, 1'b0);

        // DMA and CPU in the same cycle: DMA first, then CPU
        DMA_ADDR = 12'o300; DMA_WE = 1'b0; DMA_REQ = 1'b1;
        CPU_ADDR = 12'o200; CPU_REQ = 1'b1;
        step();
        check("sim_grant_dma", GRANT, GNT_DMA);
        check("sim_addr_dma", MEM_ADDR, 12'o300);
        repeat (MEM_LAT + 1) step();
        check("sim_dma_ack", DMA_ACK, 1'b1);
        check("sim_cpu_no_ack", CPU_ACK, 1'b0);
        DMA_REQ = 1'b0;
        step();
        check("sim_idle_grant", GRANT, GNT_NONE);
        step();
        check("sim_grant_cpu", GRANT, GNT_CPU);
        check("sim_addr_cpu", MEM_ADDR, 12'o200);
        repeat (MEM_LAT + 1) step();
        check("sim_cpu_ack", CPU_ACK, 1'b1);
        check("sim_cpu_data", RDATA, 12'o7402);
        CPU_REQ = 1'b0;
        step();

        // DMA held high, CPU waiting: anti-starvation order and throughput
        base = en_n;
        DMA_REQ = 1'b1; CPU_REQ = 1'b1;
        for (int i = 0; i < 80 && en_n < base + 6; i++) step();
        DMA_REQ = 1'b0; CPU_REQ = 1'b0;
        check("stv_strobes", en_n - base, 6);
        wait_idle("stv_idle");
        for (int k = 0; k < 6; k++)
            check($sformatf("stv_grant%0d", k), en_gnt[base+k], exp_gnt[k]);
        for (int k = 1; k < 6; k++)
            check($sformatf("stv_period%0d", k),
                  en_cyc[base+k] - en_cyc[base+k-1], MEM_LAT + 3);

        // RESET during WAIT, then re-assert
        CPU_ADDR = 12'o0017; CPU_WE = 1'b0; CPU_REQ = 1'b1;
        step();
        step();
        check("rw_in_wait", BUSY, 1'b1);
        RESET = 1'b1; CPU_REQ = 1'b0;
        step();
        check("rw_busy", BUSY, 1'b0);
        check("rw_grant", GRANT, GNT_NONE);
        check("rw_ack", CPU_ACK, 1'b0);
        check("rw_mem_en", MEM_EN, 1'b0);
        RESET = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (CPU_ACK || BUSY) acks++;
        end
        check("rw_no_activity", acks, 0);
        CPU_REQ = 1'b1;
        step();
        check("rw_re_en", MEM_EN, 1'b1);
        repeat (MEM_LAT + 1) step();
        check("rw_re_ack", CPU_ACK, 1'b1);
        check("rw_re_data", RDATA, 12'o1234);
        CPU_REQ = 1'b0;
        step();

        check("never_grant3", g3_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and cycle controller for the PDP-8 core memory (4K × 12). It sits between the memory array and up to three requesters:

- the CPU datapath, driven by the Sequencer phase strobes;
- the data-break (DMA) channel;
- the front-panel examine/deposit logic.

Each access is sequenced as one arbitration, issue, wait and acknowledge cycle, under fixed priority with a CPU anti-starvation guard.

## Interface
Parameters:
- AW, 12, address width
- DW, 12, data width
- MEM_LAT, 2, cycles from MEM_EN to valid MEM_RDATA (legal range 1..7)
- CPU_MAX_SKIP, 2, consecutive non-CPU grants tolerated while CPU_REQ is pending

Ports (reset is RESET, synchronous, active-high; clock is CLK):
- CLK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- CPU_REQ, CPU_WE  in  1  CPU request, write enable
- CPU_ADDR  in  AW  CPU address
- CPU_WDATA  in  DW  CPU write data
- CPU_ACK  out  1  one-cycle completion pulse to CPU
- DMA_REQ, DMA_WE, DMA_ADDR, DMA_WDATA, DMA_ACK  as CPU_*, data-break channel
- PNL_REQ, PNL_WE, PNL_ADDR, PNL_WDATA, PNL_ACK  as CPU_*, front panel (see Configuration)
- RDATA  out  DW  read data, valid in any ACK cycle
- MEM_EN  out  1  memory access strobe, one cycle
- MEM_WE  out  1  write qualifier, meaningful only with MEM_EN
- MEM_ADDR  out  AW  latched address
- MEM_WDATA  out  DW  latched write data
- MEM_RDATA  in  DW  memory read data
- GRANT  out  2  current owner: 0 none, 1 CPU, 2 DMA, 3 PNL
- BUSY  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE → ISSUE → WAIT → ACK → IDLE.
- IDLE:
  - Sample the REQ inputs and pick a winner.
  - Latch the winner's WE, ADDR and WDATA, set GRANT, go to ISSUE.
  - With no request, stay in IDLE.
- Priority: DMA > PNL > CPU.
  - Exception: when the skip counter equals CPU_MAX_SKIP and CPU_REQ=1, the CPU wins.
- Skip counter:
  - Increments on each DMA or PNL grant made while CPU_REQ=1.
  - Clears on a CPU grant, and on any grant made while CPU_REQ=0.
  - Saturates at CPU_MAX_SKIP.
- ISSUE: MEM_EN=1 and MEM_WE=latched WE for exactly one cycle.
- WAIT:
  - Lasts MEM_LAT cycles.
  - For a read, MEM_RDATA is captured into RDATA on the last WAIT edge.
  - For a write, RDATA is left unchanged.
- ACK: the owner's ACK=1 for one cycle, then back to IDLE. GRANT clears to 0 on entry to IDLE.
- Requester rule:
  - Hold REQ, WE, ADDR and WDATA stable from assertion through ACK.
  - REQ still high in the cycle after ACK is a new request, which gives back-to-back service.
  - A requester's inputs are don't-care once it is latched, except REQ as an arbitration input.
- Dropping REQ mid-access does not abort the access; ACK is still issued.
- Simultaneous requests: resolved only in IDLE. Losers wait without any side effect.
- RESET mid-access:
  - Next state is IDLE, all ACKs and MEM_EN are 0, the skip counter is 0.
  - The in-flight request is discarded and the requester must re-assert.

## Timing
- Reset values:
  - MEM_EN, MEM_WE and all ACKs are 0.
  - GRANT is 0, BUSY is 0.
  - MEM_ADDR, MEM_WDATA and RDATA are 0.
- Latency: REQ sampled in IDLE at cycle 0 → MEM_EN in cycle 1 → WAIT in cycles 2..MEM_LAT+1 → ACK in cycle MEM_LAT+2.
- Throughput: one access per MEM_LAT+3 cycles; the next IDLE follows ACK.
- All outputs are registered. No combinational path from REQ to ACK or MEM_*.

## Configuration
- PANEL_PORT_EN defined:
  - The PNL_* ports exist.
  - GRANT=3 is reachable.
  - PNL grants count as skips.
- PANEL_PORT_EN undefined:
  - The PNL_* ports are removed.
  - Arbitration is DMA > CPU with the same skip guard.
  - GRANT is never 3.

## Structure
- Shared package pdp8_pkg holds:
  - the GRANT encoding constants (GNT_NONE, GNT_CPU, GNT_DMA, GNT_PNL);
  - the FSM state enum;
  - the PDP-8 AW and DW constants.
- One sub-module: mem_cycle_timer, a loadable down-counter that produces the WAIT-done pulse from MEM_LAT.
- Priority selection and the skip counter stay in the top level.

## Test plan
- Single CPU read, MEM_LAT=2, memory[0o200]=0o7402:
  - MEM_EN in cycle 1, CPU_ACK in cycle 4, RDATA=0o7402.
- DMA and CPU requests in the same cycle:
  - DMA is granted first (GRANT=2), then CPU once DMA_ACK completes.
- DMA held permanently high with CPU requesting, CPU_MAX_SKIP=2:
  - Grant order DMA, DMA, CPU, DMA, DMA, CPU.
- CPU write of 0o1234 to 0o0017:
  - One MEM_EN with MEM_WE=1, ADDR=0o0017, WDATA=0o1234; RDATA unchanged.
- RESET asserted in a WAIT cycle:
  - Next cycle is IDLE, no ACK, BUSY=0.
  - The re-asserted request then completes normally.
- Build without PANEL_PORT_EN, DMA and CPU back-to-back:
  - GRANT never equals 3.
  - Each access takes exactly MEM_LAT+3 cycles.
